// File: rtl/bcd_to_binary.sv
// Sequential signed-magnitude BCD to binary converter (reverse double-dabble, one shift per clock).
// Optional input digit validation is built when BCD2BIN_DIGIT_CHECK_EN is defined.
module bcd_to_binary #(
  parameter int unsigned BIN_WIDTH  = 20,
  parameter int unsigned BCD_DIGITS = 5,
  parameter int unsigned IS_SIGNED  = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [BCD_DIGITS*4-1:0] i_bcd,
  input  logic                    i_is_negative,
  input  logic                    i_in_valid,
  output logic                    o_in_ready,
  output logic [BIN_WIDTH-1:0]    o_binary,
  output logic                    o_overflow,
  output logic                    o_digit_err,
  output logic                    o_out_valid,
  input  logic                    i_out_ready
);

  localparam int unsigned BcdW = BCD_DIGITS * 4;
  localparam int unsigned CntW = $clog2(BIN_WIDTH + 1);

  localparam logic [CntW-1:0]      LastCnt = CntW'(BIN_WIDTH - 1);
  localparam logic [CntW-1:0]      CntOne  = CntW'(1);
  localparam logic [BIN_WIDTH-1:0] MaxPos  = {1'b0, {(BIN_WIDTH - 1){1'b1}}};
  localparam logic [BIN_WIDTH-1:0] MinNeg  = {1'b1, {(BIN_WIDTH - 1){1'b0}}};
  localparam logic [BIN_WIDTH-1:0] BinOne  = BIN_WIDTH'(1);
  localparam logic [BIN_WIDTH-1:0] AllOnes = '1;

  typedef enum logic [1:0] {StIdle, StShift, StFinal, StDone} state_e;

  state_e                r_state;
  state_e                w_state_nx;
  logic [BcdW-1:0]       r_bcd;
  logic [BIN_WIDTH-1:0]  r_bin;
  logic                  r_sign;
  logic [CntW-1:0]       r_count;
  logic [BIN_WIDTH-1:0]  r_binary;
  logic                  r_overflow;
  logic                  r_out_valid;

  logic [BcdW-1:0]       w_shift_bcd;
  logic [BcdW-1:0]       w_step_bcd;
  logic [BIN_WIDTH-1:0]  w_shift_bin;
  logic                  w_mag_ovf;
  logic [BIN_WIDTH-1:0]  w_neg_mag;
  logic [BIN_WIDTH-1:0]  w_binary_nx;
  logic                  w_overflow_nx;

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= StIdle;
    else       r_state <= w_state_nx;
  end

  // Next-state logic
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      StIdle:  if (i_in_valid) w_state_nx = StShift;
      StShift: if (r_count == LastCnt) w_state_nx = StFinal;
      StFinal: w_state_nx = StDone;
      StDone:  if (i_out_ready) w_state_nx = StIdle;
      default: w_state_nx = StIdle;
    endcase
  end

  // Output / datapath next-value logic
  always_comb begin
    o_in_ready  = (r_state == StIdle);
    w_shift_bcd = r_bcd >> 1;
    w_shift_bin = {r_bcd[0], r_bin[BIN_WIDTH-1:1]};
    w_step_bcd  = w_shift_bcd;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (w_shift_bcd[4*i +: 4] >= 4'd8) w_step_bcd[4*i +: 4] = w_shift_bcd[4*i +: 4] - 4'd3;
    end

    // Any BCD residue after BIN_WIDTH shifts means the magnitude did not fit.
    w_mag_ovf = |r_bcd;
    w_neg_mag = ~r_bin + BinOne;
    if (IS_SIGNED == 0) begin
      w_binary_nx   = w_mag_ovf ? AllOnes : r_bin;
      w_overflow_nx = w_mag_ovf;
    end else if (!r_sign) begin
      w_overflow_nx = w_mag_ovf || (r_bin > MaxPos);
      w_binary_nx   = w_overflow_nx ? MaxPos : r_bin;
    end else begin
      w_overflow_nx = w_mag_ovf || (r_bin > MinNeg);
      w_binary_nx   = w_overflow_nx ? MinNeg : w_neg_mag;
    end
  end

`ifdef BCD2BIN_DIGIT_CHECK_EN
  logic r_bad;
  logic r_digit_err;
  logic w_bad_in;

  always_comb begin
    w_bad_in = 1'b0;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (i_bcd[4*i +: 4] > 4'd9) w_bad_in = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_bad       <= 1'b0;
      r_digit_err <= 1'b0;
    end else if (r_state == StIdle && i_in_valid) begin
      r_bad <= w_bad_in;
    end else if (r_state == StFinal) begin
      r_digit_err <= r_bad;
    end
  end

  assign o_digit_err = r_digit_err;
`else
  assign o_digit_err = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_bcd       <= '0;
      r_bin       <= '0;
      r_sign      <= 1'b0;
      r_count     <= '0;
      r_binary    <= '0;
      r_overflow  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (i_in_valid) begin
            r_bcd   <= i_bcd;
            r_bin   <= '0;
            r_sign  <= (IS_SIGNED != 0) && i_is_negative;
            r_count <= '0;
          end
        end
        StShift: begin
          r_bcd   <= w_step_bcd;
          r_bin   <= w_shift_bin;
          r_count <= r_count + CntOne;
        end
        StFinal: begin
`ifdef BCD2BIN_DIGIT_CHECK_EN
          r_binary   <= r_bad ? '0 : w_binary_nx;
          r_overflow <= r_bad ? 1'b0 : w_overflow_nx;
`else
          r_binary   <= w_binary_nx;
          r_overflow <= w_overflow_nx;
`endif
          r_out_valid <= 1'b1;
        end
        StDone: begin
          if (i_out_ready) r_out_valid <= 1'b0;
        end
        default: r_out_valid <= 1'b0;
      endcase
    end
  end

  assign o_binary    = r_binary;
  assign o_overflow  = r_overflow;
  assign o_out_valid = r_out_valid;

endmodule

// File: doc/bcd_to_binary.md
# bcd_to_binary

Sequential converter from signed-magnitude BCD to binary, using reverse double-dabble (shift right; subtract 3 from any digit ≥ 8). It performs the inverse of the binary-to-BCD path: keypad or display-side BCD operands plus a sign flag become two's-complement (or unsigned) integers for the calculator datapath. Both sides use a valid/ready handshake, and it runs one shift per clock.

## Interface
- BIN_WIDTH, 20, output binary width
- BCD_DIGITS, 5, number of BCD input digits
- IS_SIGNED, 1, 1 = two's-complement output honouring is_negative; 0 = unsigned, is_negative ignored
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- bcd  input  BCD_DIGITS*4  BCD operand, digit 0 in [3:0]
- is_negative  input  1  sign of operand (1 = negative)
- in_valid  input  1  operand presented
- in_ready  output  1  converter idle, can accept
- binary  output  BIN_WIDTH  converted result; signed when IS_SIGNED=1
- overflow  output  1  result saturated
- digit_err  output  1  some input digit > 9 (see Configuration)
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result

## Operation
- States: IDLE, SHIFT, FINAL, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready, capture the register pair {bcd_reg, bin_reg} = {bcd, 0}.
  - Capture sign = IS_SIGNED ? is_negative : 0.
  - Clear count; go to SHIFT.
- SHIFT, one step per cycle:
  - Shift {bcd_reg, bin_reg} right by 1.
  - Then, for each 4-bit digit of the shifted bcd_reg that is ≥ 8, subtract 3.
  - count++.
  - After BIN_WIDTH steps, go to FINAL.
- FINAL, one cycle; register binary, overflow and digit_err, set out_valid, go to DONE.
  - mag = bin_reg. mag_ovf = (bcd_reg != 0), meaning bits were lost.
  - Unsigned (sign=0, IS_SIGNED=0):
    - If mag_ovf, binary = 2^BIN_WIDTH−1 and overflow=1.
    - Otherwise binary = mag.
  - Signed positive: if mag_ovf or mag > 2^(BIN_WIDTH−1)−1, binary = 2^(BIN_WIDTH−1)−1 and overflow=1.
  - Signed negative:
    - If mag_ovf or mag > 2^(BIN_WIDTH−1), binary = −2^(BIN_WIDTH−1) and overflow=1.
    - Otherwise binary = ~mag+1.
    - Negative zero yields 0 with overflow=0.
- DONE:
  - out_valid=1. binary, overflow and digit_err are held stable.
  - On out_ready, go to IDLE and clear out_valid.
  - in_ready is 0 in DONE, so there is no same-cycle accept.
- in_valid is ignored outside IDLE. Input values are sampled only at the accept edge.

## Timing
- Reset values:
  - state=IDLE, so in_ready=1.
  - binary=0, overflow=0, digit_err=0, out_valid=0, count=0.
- Reset asserted mid-conversion aborts it immediately. No out_valid is produced for the aborted operand.
- Latency: if accepted at edge k, out_valid rises after edge k+BIN_WIDTH+1 (21 cycles at defaults).
- Minimum issue interval is BIN_WIDTH+3 cycles: accept, then shifts, then FINAL, then a DONE handshake in the same cycle out_valid rises, then return to IDLE.
- Back-pressure: while out_ready=0, DONE holds indefinitely and outputs do not change.
- in_ready is a decode of state==IDLE. All other outputs are registered.
- Count register width is $clog2(BIN_WIDTH+1).

## Configuration
- BCD2BIN_DIGIT_CHECK_EN defined:
  - At accept, flag whether any input digit is > 9; carry the flag to FINAL.
  - If flagged, FINAL forces binary=0, overflow=0, digit_err=1.
  - Latency is unchanged.
- BCD2BIN_DIGIT_CHECK_EN undefined:
  - digit_err is tied 0 and no check logic is built.
  - Invalid digits run through the algorithm unmodified. The result is deterministic but unspecified.

## Test plan
- Defaults, bcd=20'h12345, is_negative=0, out_ready=1 → after 21 cycles: binary=12345 (0x03039), overflow=0, one-cycle out_valid.
- bcd=20'h99999, is_negative=1 → binary=20'hE7961 (−99999); bcd=0, is_negative=1 → binary=0, overflow=0.
- BIN_WIDTH=8, BCD_DIGITS=3, IS_SIGNED=1:
  - bcd=12'h200 → 127, overflow=1.
  - bcd=12'h128, negative → −128 (8'h80), overflow=0.
  - bcd=12'h129, negative → 8'h80, overflow=1.
- IS_SIGNED=0, BIN_WIDTH=8, BCD_DIGITS=3:
  - bcd=12'h255, is_negative=1 → binary=255, overflow=0.
  - bcd=12'h256 → 255, overflow=1.
- Hold out_ready=0 for 10 cycles after out_valid → out_valid and binary stable, in_ready=0, a new in_valid is not accepted. Raise out_ready → in_ready=1 next cycle, the next operand is accepted.
- Assert reset at SHIFT step 7 → out_valid stays 0, in_ready=1 after release, next operand converts correctly. With BCD2BIN_DIGIT_CHECK_EN, bcd=20'h1A345 → binary=0, digit_err=1.
